id_hazard_ctrl: RTL and testbench
=================================

# id_hazard_ctrl

Hazard and sequencing controller for the MIPS decode stage. It watches the instruction in IF/ID, the load in ID/EX and branch resolution in EX/MEM. It drives PC and IF/ID write enables, the control-bubble select into ID/EX, and the pipeline flush strobes. It also keeps saturating stall and flush performance counters.

## Interface
- CNT_W, 32, width of each performance counter
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_id_opcode  in  6  IF/ID instruction bits [31:26]
- if_id_rs  in  5  IF/ID instruction bits [25:21]
- if_id_rt  in  5  IF/ID instruction bits [20:16]
- id_ex_memread  in  1  M-group MemRead bit currently held in ID/EX
- id_ex_rt  in  5  destination rt held in ID/EX
- ex_mem_branch_taken  in  1  branch resolved taken in EX/MEM (PCSrc)
- ext_stall  in  1  front-end stall request (instruction memory not ready)
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF/ID load enable
- id_bubble  out  1  forces WB/M/EX control into ID/EX to zero
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  synchronous clear of that pipeline register
- state  out  2  current FSM state encoding
- stall_cnt  out  CNT_W  cycles with pc_write=0
- flush_cnt  out  CNT_W  accepted taken branches

## Operation
- Source use is derived from the opcode:
  - uses_rs is true unless the opcode is 0x02 (j) or 0x03 (jal).
  - uses_rt is true for opcodes 0x00, 0x04, 0x05 and 0x2B.
- Load-use condition: lu = id_ex_memread & id_ex_rt≠0 & ((uses_rs & rs==id_ex_rt) | (uses_rt & rt==id_ex_rt)).
- States: RUN=0, STALL=1, HOLD=2, FLUSH=3. Outputs are Mealy: state plus current inputs. Priority is branch > ext_stall > load-use.
- Branch taken (any state):
  - All three flushes = 1, pc_write = 1, if_id_write = 1, id_bubble = 0.
  - flush_cnt increments. Next state is FLUSH.
- Else ext_stall:
  - pc_write = 0, if_id_write = 0, id_bubble = 1.
  - Next state is HOLD.
- Else lu, evaluated only in RUN and HOLD:
  - pc_write = 0, if_id_write = 0, id_bubble = 1.
  - Next state is STALL.
- Else normal: pc_write = 1, if_id_write = 1, id_bubble = 0, flushes = 0. Next state is RUN.
- In STALL and FLUSH, lu is masked:
  - After STALL, ID/EX holds a bubble, so at most one consecutive load-use bubble is issued.
  - After FLUSH, IF/ID holds a nop.
- stall_cnt increments every cycle pc_write=0 while rst_n is high.
- Both counters saturate at 2^CNT_W−1 and never wrap.
- While rst_n is low:
  - state = RUN, counters = 0.
  - pc_write = 0, if_id_write = 0, id_bubble = 1, all flushes = 0.

## Timing
- Input to output is combinational within the same cycle. There is no registered latency on control outputs.
- State and counters update on the rising clk edge. Reset takes effect immediately on rst_n falling and is released on the first edge after rst_n rises.
- A load-use stall lasts exactly 1 cycle. An ext_stall hold lasts for as many cycles as ext_stall stays high.
- Simultaneous events:
  - branch with ext_stall: flush wins, and the stall is re-evaluated in the FLUSH cycle.
  - ext_stall with lu: HOLD, then lu is re-checked on the cycle ext_stall drops.
- Reset mid-stall: the stall is abandoned and counters clear.
- Register 0 never creates a hazard.

## Structure
- A shared package holds:
  - opcode constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_SW)
  - the 2-bit state enum
- One sub-module, sat_counter (parameter W; inc, count), instantiated twice.

## Test plan
- lw $2 in ID/EX (memread=1, rt=2), add with rs=2 in IF/ID → pc_write=0, if_id_write=0, id_bubble=1 for 1 cycle. State goes RUN→STALL→RUN, stall_cnt=1.
- id_ex_rt=0 with memread=1, IF/ID rs=0 → no stall. Jump (opcode 0x02) with rs field=2 against id_ex_rt=2 → no stall.
- ex_mem_branch_taken=1 together with lu=1 → three flushes=1, pc_write=1, no bubble. Next state FLUSH with lu masked, flush_cnt=1.
- ext_stall high for 4 cycles with lu present → HOLD for 4 cycles, then 1 STALL cycle. stall_cnt=5.
- CNT_W=4, 20 consecutive stalls → stall_cnt holds at 15.
- rst_n pulled low during STALL → state=0, counters=0, pc_write=0, id_bubble=1 asynchronously. RUN resumes after release.

Source files
------------

// File: rtl/id_hazard_ctrl_pkg.sv
// Shared definitions for the decode-stage hazard controller.
// Holds the opcode constants needed to decode source-register use,
// the FSM state encoding and the source-use decode helpers.
package id_hazard_ctrl_pkg;

    localparam int unsigned OPC_W = 6;
    localparam int unsigned REG_W = 5;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OP_J     = 6'h02;
    localparam logic [OPC_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLUSH = 2'd3
    } hz_state_t;

    // Every instruction reads rs except the two absolute jumps.
    function automatic logic uses_rs(input logic [OPC_W-1:0] op);
        return !(op == OP_J || op == OP_JAL);
    endfunction

    // rt is a source only for R-type, beq/bne and sw.
    function automatic logic uses_rt(input logic [OPC_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/id_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
// Ports: clk, rst_n (async active-low), inc (count enable), count (value).
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard and sequencing controller.
// Inputs : IF/ID opcode/rs/rt, ID/EX memread/rt, EX/MEM branch taken, ext_stall.
// Outputs: pc_write, if_id_write, id_bubble, three flush strobes (all Mealy,
//          combinational from state + inputs), state, stall_cnt, flush_cnt.
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       if_id_opcode,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_rt,
    input  logic             ex_mem_branch_taken,
    input  logic             ext_stall,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_t state_q;
    hz_state_t state_d;
    logic      lu;
    logic      lu_en;
    logic      stall_inc;
    logic      flush_inc;

    // Load-use hazard against the load sitting in ID/EX; $0 never hazards.
    assign lu = id_ex_memread && (id_ex_rt != 5'd0) &&
                ((uses_rs(if_id_opcode) && (if_id_rs == id_ex_rt)) ||
                 (uses_rt(if_id_opcode) && (if_id_rt == id_ex_rt)));

    // After STALL ID/EX holds a bubble, after FLUSH IF/ID holds a nop.
    assign lu_en = (state_q == ST_RUN) || (state_q == ST_HOLD);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Mealy outputs; priority branch > ext_stall > load-use.
    always_comb begin
        state_d      = ST_RUN;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_bubble    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (!rst_n) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_bubble   = 1'b1;
        end else if (ex_mem_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_d      = ST_FLUSH;
        end else if (ext_stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_bubble   = 1'b1;
            state_d     = ST_HOLD;
        end else if (lu && lu_en) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_bubble   = 1'b1;
            state_d     = ST_STALL;
        end
    end

    assign state     = state_q;
    assign stall_inc = rst_n && !pc_write;
    assign flush_inc = rst_n && ex_mem_branch_taken;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Scenario bench for id_hazard_ctrl: a 32-bit-counter instance plus a
// 4-bit-counter instance sharing all inputs (for saturation).
module tb_id_hazard_ctrl;

    typedef struct packed {
        logic        pcw;
        logic        ifw;
        logic        bub;
        logic [2:0]  fl;
        logic [1:0]  st;
        logic [31:0] sc;
        logic [31:0] fc;
        logic [3:0]  sc4;
        logic [3:0]  fc4;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  if_id_opcode = '0;
    logic [4:0]  if_id_rs = '0;
    logic [4:0]  if_id_rt = '0;
    logic        id_ex_memread = 1'b0;
    logic [4:0]  id_ex_rt = '0;
    logic        ex_mem_branch_taken = 1'b0;
    logic        ext_stall = 1'b0;

    logic        pc_write, if_id_write, id_bubble;
    logic        if_id_flush, id_ex_flush, ex_mem_flush;
    logic [1:0]  state;
    logic [31:0] stall_cnt, flush_cnt;
    logic        s_pc_write, s_if_id_write, s_id_bubble;
    logic        s_if_id_flush, s_id_ex_flush, s_ex_mem_flush;
    logic [1:0]  s_state;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int total = 0;
    int bad = 0;
    obs_t exp_q[$];
    obs_t act_q[$];

    always #5 clk = ~clk;

    id_hazard_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_id_opcode(if_id_opcode), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
        .ex_mem_branch_taken(ex_mem_branch_taken), .ext_stall(ext_stall),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_bubble(id_bubble),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    id_hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .if_id_opcode(if_id_opcode), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
        .ex_mem_branch_taken(ex_mem_branch_taken), .ext_stall(ext_stall),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write), .id_bubble(s_id_bubble),
        .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush), .ex_mem_flush(s_ex_mem_flush),
        .state(s_state), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // Expected observation; the 4-bit instance sees identical stimulus, so
    // its counters are the 32-bit values clamped at 15.
    function automatic obs_t mk(input logic pcw, input logic ifw, input logic bub,
                                input logic [2:0] fl, input logic [1:0] st,
                                input int sc, input int fc);
        obs_t o;
        o.pcw = pcw; o.ifw = ifw; o.bub = bub; o.fl = fl; o.st = st;
        o.sc  = 32'(sc);
        o.fc  = 32'(fc);
        o.sc4 = (sc > 15) ? 4'd15 : 4'(sc);
        o.fc4 = (fc > 15) ? 4'd15 : 4'(fc);
        return o;
    endfunction

    // One cycle: drive after the edge, queue expectation, sample mid-cycle.
    task automatic cyc(input logic r, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic mr, input logic [4:0] xrt,
                       input logic br, input logic es, input obs_t e);
        obs_t a;
        @(posedge clk);
        #1;
        rst_n = r; if_id_opcode = op; if_id_rs = rs; if_id_rt = rt;
        id_ex_memread = mr; id_ex_rt = xrt; ex_mem_branch_taken = br; ext_stall = es;
        exp_q.push_back(e);
        #3;
        a.pcw = pc_write; a.ifw = if_id_write; a.bub = id_bubble;
        a.fl  = {if_id_flush, id_ex_flush, ex_mem_flush};
        a.st  = state; a.sc = stall_cnt; a.fc = flush_cnt;
        a.sc4 = s_stall_cnt; a.fc4 = s_flush_cnt;
        act_q.push_back(a);
    endtask

    // Reset for one cycle (with a hazard present, which reset must override).
    task automatic do_reset();
        cyc(0, 6'h00, 5'd2, 5'd3, 1, 5'd2, 1, 1, mk(0, 0, 1, 3'b000, 2'd0, 0, 0));
    endtask

    task automatic test_reset();
        do_reset();
        cyc(0, 6'h00, 5'd2, 5'd3, 1, 5'd2, 1, 1, mk(0, 0, 1, 3'b000, 2'd0, 0, 0));
        cyc(1, 6'h00, 5'd0, 5'd0, 0, 5'd0, 0, 0, mk(1, 1, 0, 3'b000, 2'd0, 0, 0));
        cyc(1, 6'h00, 5'd0, 5'd0, 0, 5'd0, 0, 0, mk(1, 1, 0, 3'b000, 2'd0, 0, 0));
        while (exp_q.size() > 0) begin
            obs_t e, a;
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e) begin bad++; $display("FAIL reset got=%h exp=%h", a, e); end
        end
    endtask

    task automatic test_load_use();
        do_reset();
        cyc(1, 6'h00, 5'd2, 5'd3, 1, 5'd2, 0, 0, mk(0, 0, 1, 3'b000, 2'd0, 0, 0));
        cyc(1, 6'h00, 5'd2, 5'd3, 1, 5'd2, 0, 0, mk(1, 1, 0, 3'b000, 2'd1, 1, 0));
        cyc(1, 6'h00, 5'd0, 5'd0, 0, 5'd0, 0, 0, mk(1, 1, 0, 3'b000, 2'd0, 1, 0));
        while (exp_q.size() > 0) begin
            obs_t e, a;
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e) begin bad++; $display("FAIL load_use got=%h exp=%h", a, e); end
        end
    endtask

    task automatic test_no_hazard();
        do_reset();
        cyc(1, 6'h00, 5'd0, 5'd0, 1, 5'd0, 0, 0, mk(1, 1, 0, 3'b000, 2'd0, 0, 0)); // $0
        cyc(1, 6'h02, 5'd2, 5'd0, 1, 5'd2, 0, 0, mk(1, 1, 0, 3'b000, 2'd0, 0, 0)); // j, rs
        cyc(1, 6'h03, 5'd0, 5'd2, 1, 5'd2, 0, 0, mk(1, 1, 0, 3'b000, 2'd0, 0, 0)); // jal, rt
        cyc(1, 6'h23, 5'd5, 5'd2, 1, 5'd2, 0, 0, mk(1, 1, 0, 3'b000, 2'd0, 0, 0)); // lw rt
        cyc(1, 6'h00, 5'd2, 5'd3, 0, 5'd2, 0, 0, mk(1, 1, 0, 3'b000, 2'd0, 0, 0)); // no load
        cyc(1, 6'h2B, 5'd5, 5'd2, 1, 5'd2, 0, 0, mk(0, 0, 1, 3'b000, 2'd0, 0, 0)); // sw rt
        cyc(1, 6'h05, 5'd7, 5'd7, 1, 5'd7, 0, 0, mk(1, 1, 0, 3'b000, 2'd1, 1, 0)); // masked
        cyc(1, 6'h04, 5'd1, 5'd7, 1, 5'd7, 0, 0, mk(0, 0, 1, 3'b000, 2'd0, 1, 0)); // beq rt
        while (exp_q.size() > 0) begin
            obs_t e, a;
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e) begin bad++; $display("FAIL no_hazard got=%h exp=%h", a, e); end
        end
    endtask

    task automatic test_branch();
        do_reset();
        cyc(1, 6'h00, 5'd2, 5'd3, 1, 5'd2, 1, 0, mk(1, 1, 0, 3'b111, 2'd0, 0, 0));
        cyc(1, 6'h00, 5'd2, 5'd3, 1, 5'd2, 0, 0, mk(1, 1, 0, 3'b000, 2'd3, 0, 1));
        cyc(1, 6'h00, 5'd2, 5'd3, 1, 5'd2, 0, 0, mk(0, 0, 1, 3'b000, 2'd0, 0, 1));
        cyc(1, 6'h00, 5'd2, 5'd3, 1, 5'd2, 1, 1, mk(1, 1, 0, 3'b111, 2'd1, 1, 1));
        cyc(1, 6'h00, 5'd0, 5'd0, 0, 5'd0, 0, 1, mk(0, 0, 1, 3'b000, 2'd3, 1, 2));
        cyc(1, 6'h00, 5'd0, 5'd0, 0, 5'd0, 0, 0, mk(1, 1, 0, 3'b000, 2'd2, 2, 2));
        cyc(1, 6'h00, 5'd0, 5'd0, 0, 5'd0, 0, 0, mk(1, 1, 0, 3'b000, 2'd0, 2, 2));
        while (exp_q.size() > 0) begin
            obs_t e, a;
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e) begin bad++; $display("FAIL branch got=%h exp=%h", a, e); end
        end
    endtask

    task automatic test_hold();
        do_reset();
        for (int i = 0; i < 4; i++)
            cyc(1, 6'h00, 5'd2, 5'd3, 1, 5'd2, 0, 1,
                mk(0, 0, 1, 3'b000, (i == 0) ? 2'd0 : 2'd2, i, 0));
        cyc(1, 6'h00, 5'd2, 5'd3, 1, 5'd2, 0, 0, mk(0, 0, 1, 3'b000, 2'd2, 4, 0));
        cyc(1, 6'h00, 5'd2, 5'd3, 1, 5'd2, 0, 0, mk(1, 1, 0, 3'b000, 2'd1, 5, 0));
        cyc(1, 6'h00, 5'd0, 5'd0, 0, 5'd0, 0, 0, mk(1, 1, 0, 3'b000, 2'd0, 5, 0));
        while (exp_q.size() > 0) begin
            obs_t e, a;
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e) begin bad++; $display("FAIL hold got=%h exp=%h", a, e); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 20; i++)
            cyc(1, 6'h00, 5'd0, 5'd0, 0, 5'd0, 0, 1,
                mk(0, 0, 1, 3'b000, (i == 0) ? 2'd0 : 2'd2, i, 0));
        cyc(1, 6'h00, 5'd0, 5'd0, 0, 5'd0, 0, 0, mk(1, 1, 0, 3'b000, 2'd2, 20, 0));
        for (int i = 0; i < 18; i++)
            cyc(1, 6'h00, 5'd0, 5'd0, 0, 5'd0, 1, 0,
                mk(1, 1, 0, 3'b111, (i == 0) ? 2'd0 : 2'd3, 20, i));
        cyc(1, 6'h00, 5'd0, 5'd0, 0, 5'd0, 0, 0, mk(1, 1, 0, 3'b000, 2'd3, 20, 18));
        while (exp_q.size() > 0) begin
            obs_t e, a;
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e) begin bad++; $display("FAIL back_to_back got=%h exp=%h", a, e); end
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        cyc(1, 6'h00, 5'd2, 5'd3, 1, 5'd2, 0, 0, mk(0, 0, 1, 3'b000, 2'd0, 0, 0));
        cyc(0, 6'h00, 5'd2, 5'd3, 1, 5'd2, 0, 0, mk(0, 0, 1, 3'b000, 2'd0, 0, 0));
        cyc(1, 6'h00, 5'd2, 5'd3, 1, 5'd2, 0, 0, mk(0, 0, 1, 3'b000, 2'd0, 0, 0));
        cyc(1, 6'h00, 5'd0, 5'd0, 0, 5'd0, 0, 0, mk(1, 1, 0, 3'b000, 2'd1, 1, 0));
        cyc(1, 6'h00, 5'd0, 5'd0, 0, 5'd0, 0, 0, mk(1, 1, 0, 3'b000, 2'd0, 1, 0));
        while (exp_q.size() > 0) begin
            obs_t e, a;
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e) begin bad++; $display("FAIL reset_mid_stall got=%h exp=%h", a, e); end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch();
        test_hold();
        test_back_to_back();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
